// File: rtl/interleaved_reg_fifo.sv
// interleaved_reg_fifo: show-ahead FIFO striped round-robin across NUM_LANES register lanes
module interleaved_reg_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int NUM_LANES   = 2,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          clear,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          almost_full,
  output logic                          overflow
);
  localparam int LANE_DEPTH = FIFO_DEPTH / NUM_LANES;
  localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam int PW = LANE_DEPTH > 1 ? $clog2(LANE_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [NUM_LANES][LANE_DEPTH];
  logic [PW-1:0] wr_ptr [NUM_LANES];
  logic [PW-1:0] rd_ptr [NUM_LANES];
  logic [LW-1:0] wr_lane, rd_lane;
  logic push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return p == PW'(LANE_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [LW-1:0] lane_next(input logic [LW-1:0] l);
    return l == LW'(NUM_LANES - 1) ? '0 : l + LW'(1);
  endfunction

  assign in_ready    = count != CW'(FIFO_DEPTH);
  assign out_valid   = count != '0;
  assign almost_full = count >= CW'(AFULL_LEVEL);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = mem[rd_lane][rd_ptr[rd_lane]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || clear) begin
      count    <= '0;
      overflow <= 1'b0;
      wr_lane  <= '0;
      rd_lane  <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr[wr_lane] <= ptr_next(wr_ptr[wr_lane]);
        wr_lane         <= lane_next(wr_lane);
      end
      if (pop) begin
        rd_ptr[rd_lane] <= ptr_next(rd_ptr[rd_lane]);
        rd_lane         <= lane_next(rd_lane);
      end
      count <= count + CW'(push) - CW'(pop);
      if (in_valid && !in_ready)
        overflow <= 1'b1;
    end
  end

  // storage is deliberately not reset; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_lane][wr_ptr[wr_lane]] <= in_data;
  end
endmodule
